// File: rtl/bmem_arb_pkg.sv
// Shared types for the burst-memory line arbiter: requester ids, line type and read tag entries.
package bmem_arb_pkg;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    typedef logic [255:0] line_t;

    typedef struct packed {
        req_id_t     id;
        logic        squashed;
        logic [31:0] addr;
    } tag_entry_t;

    localparam int BEATS_PER_LINE = 4;

endpackage

// File: rtl/bmem_tag_fifo.sv
// In-order FIFO of issued read tags (depth 1-4); BMEM_ARB_IKILL_EN adds a port that squashes queued I entries.
module bmem_tag_fifo
    import bmem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  tag_entry_t push_entry,
    input  logic       pop,
`ifdef BMEM_ARB_IKILL_EN
    input  logic       mark_squash,
`endif
    output tag_entry_t head_entry,
    output logic       full,
    output logic       empty
);

    tag_entry_t mem_reg [4];
    logic [1:0] wr_ptr_reg;
    logic [1:0] rd_ptr_reg;
    logic [2:0] count_reg;
    logic       do_push;
    logic       do_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign full       = (count_reg == 3'(DEPTH));
    assign empty      = (count_reg == 3'd0);
    assign head_entry = mem_reg[rd_ptr_reg];
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (do_push && !do_pop)      count_reg <= count_reg + 3'd1;
            else if (!do_push && do_pop) count_reg <= count_reg - 3'd1;
        end
    end

    // A push into a slot overrides a squash mark aimed at the same slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
`ifdef BMEM_ARB_IKILL_EN
                if (mark_squash && mem_reg[i].id == REQ_I) mem_reg[i].squashed <= 1'b1;
`endif
                if (do_push && wr_ptr_reg == 2'(i)) mem_reg[i] <= push_entry;
            end
        end
    end

endmodule

// File: rtl/bmem_line_arbiter.sv
// Round-robin sharing of the 64-bit burst memory port between I and D caches.
// Optional feature macro: BMEM_ARB_IKILL_EN (i_kill squashes pending/issued I reads).
module bmem_line_arbiter
    import bmem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  i_addr,
    input  logic         i_read,
    input  logic         i_kill,
    output logic [255:0] i_rdata,
    output logic [31:0]  i_raddr,
    output logic         i_resp,
    input  logic [31:0]  d_addr,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_CMD  = 2'd1;
    localparam logic [1:0] ST_WR_BEAT = 2'd2;

    logic [1:0] state_reg;
    req_id_t    last_grant_reg;
    logic       i_busy_reg;
    logic       d_busy_reg;
    logic       kill_cmd_reg;
    logic [1:0] wr_beat_reg;
    logic [1:0] wr_beat_next;
    logic [1:0] rx_beat_reg;

    logic       kill_active;
    logic       i_ok;
    logic       d_ok;
    logic       grant_i;
    logic       grant_d;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    tag_entry_t push_entry;
    tag_entry_t head_entry;
    line_t      rx_line;

    logic [9:0]  unused_addr_bits;
    logic [31:0] unused_tag_addr;
    assign unused_addr_bits = {i_addr[4:0], d_addr[4:0]};
    assign unused_tag_addr  = head_entry.addr;

`ifdef BMEM_ARB_IKILL_EN
    assign kill_active = i_kill;
`else
    logic unused_kill;
    assign unused_kill = i_kill;
    assign kill_active = 1'b0;
`endif

    // The resp cycle is excluded so a still-held level request is not re-granted.
    assign i_ok    = i_read && !i_busy_reg && !i_resp && !kill_active && !fifo_full;
    assign d_ok    = (d_read || d_write) && !d_busy_reg && !d_resp && (d_write || !fifo_full);
    assign grant_i = i_ok && (!d_ok || last_grant_reg == REQ_D);
    assign grant_d = d_ok && !grant_i;

    assign wr_beat_next = wr_beat_reg + 2'd1;
    assign fifo_push    = (state_reg == ST_RD_CMD) && bmem_ready;
    assign fifo_pop     = bmem_rvalid && (rx_beat_reg == 2'd3) && !fifo_empty;

    always_comb begin
        push_entry          = '0;
        push_entry.id       = last_grant_reg;
        push_entry.squashed = kill_cmd_reg || (kill_active && last_grant_reg == REQ_I);
        push_entry.addr     = bmem_addr;
    end

    bmem_tag_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
`ifdef BMEM_ARB_IKILL_EN
        .mark_squash(kill_active),
`endif
        .head_entry (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    for (genvar gi = 0; gi < BEATS_PER_LINE - 1; gi++) begin : g_chunk
        logic [63:0] beat_reg;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)                                        beat_reg <= '0;
            else if (bmem_rvalid && rx_beat_reg == 2'(gi)) beat_reg <= bmem_rdata;
        end
    end

    assign rx_line = {bmem_rdata, g_chunk[2].beat_reg, g_chunk[1].beat_reg, g_chunk[0].beat_reg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= REQ_D;
            i_busy_reg     <= 1'b0;
            d_busy_reg     <= 1'b0;
            kill_cmd_reg   <= 1'b0;
            wr_beat_reg    <= 2'd0;
            rx_beat_reg    <= 2'd0;
            bmem_addr      <= '0;
            bmem_read      <= 1'b0;
            bmem_write     <= 1'b0;
            bmem_wdata     <= '0;
            i_rdata        <= '0;
            i_raddr        <= '0;
            i_resp         <= 1'b0;
            d_rdata        <= '0;
            d_resp         <= 1'b0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            if (kill_active) i_busy_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (grant_i || grant_d) begin
                        last_grant_reg <= grant_i ? REQ_I : REQ_D;
                        bmem_addr      <= {(grant_i ? i_addr[31:5] : d_addr[31:5]), 5'b0};
                        kill_cmd_reg   <= 1'b0;
                        if (grant_i) i_busy_reg <= 1'b1;
                        else         d_busy_reg <= 1'b1;
                        if (grant_d && d_write) begin
                            state_reg   <= ST_WR_BEAT;
                            bmem_write  <= 1'b1;
                            bmem_wdata  <= d_wdata[63:0];
                            wr_beat_reg <= 2'd0;
                        end else begin
                            state_reg <= ST_RD_CMD;
                            bmem_read <= 1'b1;
                        end
                    end
                end
                ST_RD_CMD: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (kill_active && last_grant_reg == REQ_I) begin
                        kill_cmd_reg <= 1'b1;
                    end
                end
                ST_WR_BEAT: begin
                    if (bmem_ready) begin
                        if (wr_beat_reg == 2'd3) begin
                            bmem_write <= 1'b0;
                            d_resp     <= 1'b1;
                            d_busy_reg <= 1'b0;
                            state_reg  <= ST_IDLE;
                        end else begin
                            wr_beat_reg <= wr_beat_next;
                            bmem_wdata  <= d_wdata[{wr_beat_next, 6'd0} +: 64];
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Receive path runs independently of issue; orphan beats just advance the counter.
            if (bmem_rvalid) begin
                rx_beat_reg <= rx_beat_reg + 2'd1;
                if (fifo_pop) begin
                    if (head_entry.id == REQ_I) begin
                        if (!head_entry.squashed) begin
                            i_rdata    <= rx_line;
                            i_raddr    <= bmem_raddr;
                            i_resp     <= 1'b1;
                            i_busy_reg <= 1'b0;
                        end
                    end else begin
                        d_rdata    <= rx_line;
                        d_resp     <= 1'b1;
                        d_busy_reg <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Directed bench for bmem_line_arbiter (MAX_OUTSTANDING = 1); kill checks follow BMEM_ARB_IKILL_EN.
module tb_bmem_line_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr;
    logic         i_read;
    logic         i_kill;
    logic [255:0] i_rdata;
    logic [31:0]  i_raddr;
    logic         i_resp;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] wbeat [4];

    always #5 clk = ~clk;

    bmem_line_arbiter #(
        .MAX_OUTSTANDING(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_addr     (i_addr),
        .i_read     (i_read),
        .i_kill     (i_kill),
        .i_rdata    (i_rdata),
        .i_raddr    (i_raddr),
        .i_resp     (i_resp),
        .d_addr     (d_addr),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] line_of(input logic [63:0] seed);
        return {seed * 64'd4, seed * 64'd3, seed * 64'd2, seed};
    endfunction

    task automatic wait_read(input string tag);
        int waited = 0;
        while (bmem_read !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        chk({tag, "_issue"}, bmem_read, 1'b1);
    endtask

    task automatic send_beats(input logic [31:0] addr, input logic [63:0] seed);
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = seed * 64'(k + 1);
            bmem_raddr  = addr;
            step();
        end
        bmem_rvalid = 1'b0;
    endtask

    // Wait for the command, hold it one cycle with ready low, accept it, confirm nothing
    // else issues while the single tag slot is occupied, then return the line.
    task automatic serve_read(input string tag, input logic [31:0] exp_addr,
                              input logic exp_i, input logic [63:0] seed);
        wait_read(tag);
        chk({tag, "_addr"}, bmem_addr, exp_addr);
        step();
        chk({tag, "_hold"}, bmem_read, 1'b1);
        bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        chk({tag, "_cmd_drop"}, bmem_read, 1'b0);
        step();
        chk({tag, "_blocked"}, bmem_read, 1'b0);
        send_beats(exp_addr, seed);
        if (exp_i) begin
            chk({tag, "_i_resp"}, i_resp, 1'b1);
            chk({tag, "_d_resp"}, d_resp, 1'b0);
            chk({tag, "_i_rdata"}, i_rdata, line_of(seed));
            chk({tag, "_i_raddr"}, i_raddr, exp_addr);
        end else begin
            chk({tag, "_d_resp"}, d_resp, 1'b1);
            chk({tag, "_i_resp"}, i_resp, 1'b0);
            chk({tag, "_d_rdata"}, d_rdata, line_of(seed));
        end
    endtask

    initial begin
        rst = 1'b0;
        i_addr = '0; i_read = 1'b0; i_kill = 1'b0;
        d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        wbeat[0] = 64'hAAAA_0000_AAAA_0000;
        wbeat[1] = 64'hBBBB_1111_BBBB_1111;
        wbeat[2] = 64'hCCCC_2222_CCCC_2222;
        wbeat[3] = 64'hDDDD_3333_DDDD_3333;

        step();
        step();
        chk("rst_bmem_read", bmem_read, 1'b0);
        chk("rst_bmem_write", bmem_write, 1'b0);
        chk("rst_bmem_addr", bmem_addr, 32'h0);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        chk("rst_i_rdata", i_rdata, 256'h0);
        rst = 1'b1;
        step();

        // Tie from reset: I first, then strict alternation.
        i_addr = 32'h0000_4000; d_addr = 32'h0000_501F;
        i_read = 1'b1; d_read = 1'b1;
        serve_read("tie1_i", 32'h0000_4000, 1'b1, 64'h0101_0101_0101_0101);
        serve_read("tie2_d", 32'h0000_5000, 1'b0, 64'h0202_0202_0202_0202);
        serve_read("tie3_i", 32'h0000_4000, 1'b1, 64'h0303_0303_0303_0303);
        i_read = 1'b0;
        serve_read("tie4_d", 32'h0000_5000, 1'b0, 64'h0404_0404_0404_0404);
        d_read = 1'b0;
        step();
        chk("tie_end_resp", {i_resp, d_resp}, 2'b00);
        chk("tie_end_idle", bmem_read, 1'b0);

        // Plain I line read.
        i_addr = 32'h0000_1040; i_read = 1'b1;
        serve_read("iread", 32'h0000_1040, 1'b1, 64'h1111_1111_1111_1111);
        chk("iread_line", i_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        i_read = 1'b0;
        step();
        chk("iread_pulse", i_resp, 1'b0);

        // Tie after an I grant: D wins.
        i_addr = 32'h0000_6000; d_addr = 32'h0000_7000;
        i_read = 1'b1; d_read = 1'b1;
        serve_read("rr_d", 32'h0000_7000, 1'b0, 64'h0505_0505_0505_0505);
        d_read = 1'b0;
        serve_read("rr_i", 32'h0000_6000, 1'b1, 64'h0606_0606_0606_0606);
        i_read = 1'b0;
        step();

        // D write-back with ready pattern 1,0,1,1,0,1.
        d_addr = 32'h0000_2000;
        d_wdata = {wbeat[3], wbeat[2], wbeat[1], wbeat[0]};
        d_write = 1'b1;
        step();
        chk("wr_addr", bmem_addr, 32'h0000_2000);
        begin
            int beat = 0;
            logic [5:0] pattern = 6'b101101;
            for (int s = 0; s < 6; s++) begin
                chk($sformatf("wr_step%0d_write", s), bmem_write, 1'b1);
                chk($sformatf("wr_step%0d_data", s), bmem_wdata, wbeat[beat]);
                chk($sformatf("wr_step%0d_resp", s), d_resp, 1'b0);
                bmem_ready = pattern[s];
                step();
                if (pattern[s]) beat++;
            end
        end
        bmem_ready = 1'b0;
        chk("wr_d_resp", d_resp, 1'b1);
        chk("wr_write_drop", bmem_write, 1'b0);
        d_write = 1'b0;
        step();
        chk("wr_pulse", d_resp, 1'b0);

        // I read with i_kill pulsed after issue.
        i_addr = 32'h0000_3000; i_read = 1'b1;
        wait_read("kill");
        bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        i_kill = 1'b1;
`ifdef BMEM_ARB_IKILL_EN
        i_read = 1'b0;
`endif
        step();
        i_kill = 1'b0;
        send_beats(32'h0000_3000, 64'h0707_0707_0707_0707);
`ifdef BMEM_ARB_IKILL_EN
        chk("kill_no_resp", i_resp, 1'b0);
        step();
        chk("kill_no_resp2", i_resp, 1'b0);
        i_addr = 32'h0000_3020; i_read = 1'b1;
        serve_read("after_kill", 32'h0000_3020, 1'b1, 64'h0808_0808_0808_0808);
`else
        chk("nokill_resp", i_resp, 1'b1);
        chk("nokill_rdata", i_rdata, line_of(64'h0707_0707_0707_0707));
`endif
        i_read = 1'b0;
        step();

        // Reset while beat 2 of a write is on the bus.
        d_addr = 32'h0000_8000; d_write = 1'b1; bmem_ready = 1'b1;
        step();
        step();
        step();
        bmem_ready = 1'b0;
        chk("rstmid_beat2", bmem_wdata, wbeat[2]);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_write_async", bmem_write, 1'b0);
        chk("rstmid_wdata_async", bmem_wdata, 64'h0);
        chk("rstmid_addr_async", bmem_addr, 32'h0);
        step();
        rst = 1'b1;
        step();
        chk("restart_write", bmem_write, 1'b1);
        chk("restart_addr", bmem_addr, 32'h0000_8000);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("restart_beat%0d", k), bmem_wdata, wbeat[k]);
            bmem_ready = 1'b1;
            step();
        end
        bmem_ready = 1'b0;
        chk("restart_d_resp", d_resp, 1'b1);
        d_write = 1'b0;
        step();

        // Beats with nothing outstanding are swallowed.
        send_beats(32'h0000_9000, 64'h0909_0909_0909_0909);
        chk("orphan_resp", {i_resp, d_resp}, 2'b00);
        step();
        chk("orphan_resp2", {i_resp, d_resp}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bmem_line_arbiter.md
# bmem_line_arbiter

Shares the single 64-bit burst memory port between the instruction cache (line reads) and the data cache (line reads and write-backs). It sits between the two caches' 256-bit downward-facing ports and the bmem interface. It arbitrates round-robin, serialises 4-beat write bursts, tracks in-order read responses with a tag FIFO, and reassembles 4 beats into a line for the owning requester.

## Interface
- MAX_OUTSTANDING, 2, depth of the read tag FIFO (number of issued, unanswered reads); legal range 1–4.
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-low: asserted when 0.
- i_addr  in  32  I-line address; bits [4:0] ignored.
- i_read  in  1  I read request; level, held until i_resp.
- i_kill  in  1  squash the in-flight I read (see Configuration).
- i_rdata  out  256  I line data; valid with i_resp.
- i_raddr  out  32  address of the returned I line.
- i_resp  out  1  one-cycle I completion pulse.
- d_addr  in  32  D-line address; bits [4:0] ignored.
- d_read  in  1  D read request; level, held until d_resp.
- d_write  in  1  D write-back request; level, held until d_resp; never asserted together with d_read.
- d_wdata  in  256  D write line; stable while d_write.
- d_rdata  out  256  D line data; valid with d_resp.
- d_resp  out  1  one-cycle D completion pulse (read or write).
- bmem_addr  out  32  command address, bits [4:0] = 0.
- bmem_read  out  1  read command.
- bmem_write  out  1  write beat.
- bmem_wdata  out  64  write beat data.
- bmem_ready  in  1  memory accepts a command or beat this cycle.
- bmem_raddr  in  32  address of the returning burst.
- bmem_rdata  in  64  read beat.
- bmem_rvalid  in  1  read beat valid.

## Operation
- Pending: a requester asserts its request and has no issued, unanswered transaction. Each requester has at most one transaction in flight.
- Issue FSM states:
  - IDLE: select among pending requesters. If both are pending, grant the one not granted last. last_grant resets to D, so I wins the first tie.
  - RD_CMD: drive bmem_read with the line address. Leave on the first cycle with bmem_ready=1. Push {requester id, addr} into the tag FIFO, then return to IDLE.
  - WR_BEAT: drive bmem_write with the line address and beat k = d_wdata[64k+63:64k]. k advances only on cycles with bmem_ready=1. After beat 3 is accepted, pulse d_resp on the next cycle and return to IDLE.
- Reads are not granted while the tag FIFO is full. Writes may issue while reads are outstanding.
- Receive path is independent of the issue FSM:
  - 2-bit beat counter; beats are stored in chunk registers.
  - On the 4th rvalid beat, pop the tag FIFO. Drive {beat3, beat2, beat1, beat0} onto the owner's rdata and bmem_raddr onto i_raddr for an I line. Pulse the owner's resp on the next cycle.
  - Beats arriving with the tag FIFO empty are consumed and dropped.
- A write d_resp and a read i_resp in the same cycle are both delivered. A write d_resp and a read d_resp cannot coincide, because D has only one transaction in flight.

## Timing
- Reset values: every output is 0, FSM is in IDLE, FIFO is empty, beat counters are 0, last_grant = D.
- All outputs are registered.
- A request seen at edge N drives bmem_read or bmem_write from edge N+1.
- Read completion: resp rises one cycle after the 4th rvalid beat.
- Write completion: d_resp rises one cycle after the 4th accepted beat. Minimum 5 cycles from request with bmem_ready held high.
- bmem_ready low holds the current command or beat unchanged.
- Reset asserted mid-burst aborts immediately. Later beats are dropped because the FIFO is empty.
- Beat counters wrap 3 → 0.

## Configuration
- BMEM_ARB_IKILL_EN defined:
  - i_kill high while an I read is pending but not issued cancels the issue.
  - i_kill high while an I read is issued marks its FIFO entry squashed. Its beats are consumed and i_resp is suppressed.
  - I becomes pending again on the next cycle if i_read is still high.
- BMEM_ARB_IKILL_EN undefined: i_kill is ignored, and every issued read completes with i_resp.

## Structure
- Package bmem_arb_pkg holds:
  - typedef req_id_t (I = 0, D = 1)
  - typedef line_t (logic [255:0])
  - tag entry struct {req_id_t id; logic squashed; logic [31:0] addr}
  - constant BEATS_PER_LINE = 4
- Sub-module bmem_tag_fifo: synchronous FIFO of tag entries, depth MAX_OUTSTANDING, with push, pop, full and empty. When BMEM_ARB_IKILL_EN is defined, it also provides a mark-squashed port for I entries.

## Test plan
- I read only, addr 0x0000_1040, memory returns beats 0x11..,0x22..,0x33..,0x44.. → bmem_read with addr 0x1040 for one ready cycle. i_resp one cycle after the 4th beat, i_rdata = {44..,33..,22..,11..}, i_raddr = 0x1040.
- D write, addr 0x2000, bmem_ready toggling 1,0,1,1,0,1 → 4 beats in order, each held while ready=0. d_resp one cycle after the 4th accepted beat.
- I and D reads requested in the same cycle, both repeated → grants alternate I, D, I, D. Responses return in order to the correct requester.
- MAX_OUTSTANDING=1, D read issued, I read pending → I is not issued until the D line's 4th beat pops the FIFO.
- With BMEM_ARB_IKILL_EN: issue I read 0x3000, pulse i_kill, return 4 beats → no i_resp. A following I read 0x3020 completes normally.
- rst to 0 during write beat 2 → all outputs 0 asynchronously. After release, the next D write starts at beat 0.
